switch_debouncer: RTL and testbench

Input conditioner for the board slide switches: synchronises each raw `SW` bit to `CLOCK_50`, debounces it with a per-bit stability counter, and presents a clean switch state plus single-cycle rise/fall event pulses and a running count of accepted transitions. It sits between the `SW` pins and the LED/7-segment display logic, so the display path only ever sees settled switch positions.

---
 rtl/switch_debouncer_if.sv | 28 ++
 rtl/switch_debouncer.sv | 99 +++++++++
 tb/tb_switch_debouncer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch debouncer signal bundle.
//   SW          raw asynchronous switch levels (1 = up)
//   SW_STATE    debounced switch levels
//   SW_RISE     one-cycle pulse per bit on an accepted 0->1
//   SW_FALL     one-cycle pulse per bit on an accepted 1->0
//   CHANGE_CNT  running count of accepted transitions, all bits, wrapping
// master: the debouncer, which sources the clean switch view.
// slave:  the consumer (display logic), which owns the raw pins.
interface switch_debouncer_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);
  logic [0:WIDTH-1] SW;
  logic [0:WIDTH-1] SW_STATE;
  logic [0:WIDTH-1] SW_RISE;
  logic [0:WIDTH-1] SW_FALL;
  logic [CNT_W-1:0] CHANGE_CNT;

  modport master (
    input  SW,
    output SW_STATE, SW_RISE, SW_FALL, CHANGE_CNT
  );

  modport slave (
    output SW,
    input  SW_STATE, SW_RISE, SW_FALL, CHANGE_CNT
  );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch input conditioner.
// Each raw SW bit passes a two-flop synchroniser and a per-bit 24-bit
// stability counter; a new level is accepted only after it has persisted
// for DEBOUNCE_CYCLES consecutive cycles. Accepted transitions update
// SW_STATE, optionally pulse SW_RISE/SW_FALL, and bump CHANGE_CNT.
// Ports:
//   CLOCK_50  system clock, rising edge
//   RESET_N   asynchronous active-low reset
//   sw_if     switch_debouncer_if.master (SW in; SW_STATE, SW_RISE,
//             SW_FALL, CHANGE_CNT out)
// Build option:
//   SWITCH_DEBOUNCER_EDGE_EN  when defined, SW_RISE/SW_FALL pulse registers
//                             are built; otherwise both are tied to 0.
module switch_debouncer #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8
) (
  input logic                CLOCK_50,
  input logic                RESET_N,
  switch_debouncer_if.master sw_if
);

  localparam logic [23:0] TERM = 24'(DEBOUNCE_CYCLES - 1);

  logic [0:WIDTH-1] meta_q;
  logic [0:WIDTH-1] sync_q;
  logic [0:WIDTH-1] state_q, state_d;
  logic [23:0]      cnt_q [WIDTH];
  logic [23:0]      cnt_d [WIDTH];
  logic [0:WIDTH-1] accept;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;

  always_comb begin
    state_d      = state_q;
    change_cnt_d = change_cnt_q;
    accept       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any cycle of agreement drops a pending change.
      cnt_d[i] = '0;
      if (sync_q[i] != state_q[i]) begin
        if (cnt_q[i] == TERM) begin
          state_d[i] = sync_q[i];
          accept[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 24'd1;
        end
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      change_cnt_d = change_cnt_d + CNT_W'(accept[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q       <= '0;
      sync_q       <= '0;
      state_q      <= '0;
      change_cnt_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q       <= sw_if.SW;
      sync_q       <= meta_q;
      state_q      <= state_d;
      change_cnt_q <= change_cnt_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_if.SW_STATE   = state_q;
  assign sw_if.CHANGE_CNT = change_cnt_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [0:WIDTH-1] rise_q, rise_d;
  logic [0:WIDTH-1] fall_q, fall_d;

  // On an accepted bit the new level equals sync, which gives the direction.
  assign rise_d = accept & sync_q;
  assign fall_d = accept & ~sync_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_if.SW_RISE = rise_q;
  assign sw_if.SW_FALL = fall_q;
`else
  assign sw_if.SW_RISE = '0;
  assign sw_if.SW_FALL = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  switch_debouncer_if #(.WIDTH(6), .CNT_W(8)) sw_if ();

  switch_debouncer #(
    .WIDTH(6),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .sw_if   (sw_if)
  );

  typedef struct {
    int         at;
    string      tag;
    logic [0:5] st;
    logic [0:5] ri;
    logic [0:5] fa;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [0:5] exp_state = '0;
  logic [7:0] exp_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [0:5] edge_exp(input logic [0:5] v);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    return v;
`else
    return 6'b000000;
`endif
  endfunction

  function automatic exp_t mk(input int at, input string tag, input logic [0:5] st,
                              input logic [0:5] ri, input logic [0:5] fa, input logic [7:0] cnt);
    exp_t e;
    e.at = at; e.tag = tag; e.st = st; e.ri = ri; e.fa = fa; e.cnt = cnt;
    return e;
  endfunction

  // Pop and compare every expectation due at this sampling point.
  always @(negedge CLOCK_50) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      if (cur.at < cyc) begin
        chk({cur.tag, "_late"}, cyc, cur.at);
      end else begin
        chk({cur.tag, "_state"}, 32'(sw_if.SW_STATE), 32'(cur.st));
        chk({cur.tag, "_rise"},  32'(sw_if.SW_RISE),  32'(cur.ri));
        chk({cur.tag, "_fall"},  32'(sw_if.SW_FALL),  32'(cur.fa));
        chk({cur.tag, "_cnt"},   32'(sw_if.CHANGE_CNT), 32'(cur.cnt));
      end
    end
  end

  // SW driven now is captured at the next edge E = cyc+1 and accepted at E+5.
  task automatic push_change(input logic [0:5] nv, input string tag);
    int         c;
    logic [0:5] diff;
    c    = cyc;
    diff = nv ^ exp_state;
    sb.push_back(mk(c + 5, {tag, "_pre"}, exp_state, 6'b0, 6'b0, exp_cnt));
    exp_cnt = exp_cnt + 8'($countones(diff));
    sb.push_back(mk(c + 6, tag, nv, edge_exp(nv & diff), edge_exp(exp_state & diff), exp_cnt));
    exp_state = nv;
    sb.push_back(mk(c + 7, {tag, "_post"}, nv, 6'b0, 6'b0, exp_cnt));
  endtask

  task automatic settle_change(input logic [0:5] nv, input string tag);
    push_change(nv, tag);
    sw_if.SW = nv;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_state"}, 32'(sw_if.SW_STATE), 32'd0);
    chk({tag, "_rise"},  32'(sw_if.SW_RISE),  32'd0);
    chk({tag, "_fall"},  32'(sw_if.SW_FALL),  32'd0);
    chk({tag, "_cnt"},   32'(sw_if.CHANGE_CNT), 32'd0);
  endtask

  initial begin
    logic [0:5] pat;
    int         c;
    sw_if.SW = '0;
    RESET_N  = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check_outputs_zero("reset");
    RESET_N = 1'b1;
    c = cyc;
    for (int k = 1; k <= 3; k++) sb.push_back(mk(c + k, "idle", 6'b0, 6'b0, 6'b0, 8'd0));
    repeat (4) @(negedge CLOCK_50);

    settle_change(6'b001000, "rise2");

    // Glitches of 2 cycles on SW[2] must never be accepted.
    c = cyc;
    for (int k = 1; k <= 14; k++) sb.push_back(mk(c + k, "bounce", exp_state, 6'b0, 6'b0, exp_cnt));
    for (int k = 0; k < 8; k++) begin
      pat = sw_if.SW;
      pat[2] = (k % 4 < 2) ? 1'b0 : 1'b1;
      sw_if.SW = pat;
      @(negedge CLOCK_50);
    end
    repeat (8) @(negedge CLOCK_50);

    settle_change(6'b000000, "fall2");
    settle_change(6'b111111, "all_rise");
    settle_change(6'b000000, "all_fall");

    // 14 transitions so far; 236 more bring the counter to 250.
    for (int k = 0; k < 236; k++) settle_change(exp_state ^ 6'b100000, "pre_wrap");
    sb.push_back(mk(cyc + 1, "cnt250", exp_state, 6'b0, 6'b0, 8'd250));
    repeat (2) @(negedge CLOCK_50);
    for (int k = 0; k < 256; k++) settle_change(exp_state ^ 6'b100000, "wrap");
    sb.push_back(mk(cyc + 1, "wrapped", 6'b0, 6'b0, 6'b0, 8'd250));
    repeat (2) @(negedge CLOCK_50);

    // Reset while cnt[1] == 2 with a pending rise on SW[1].
    c = cyc;
    for (int k = 1; k <= 4; k++) sb.push_back(mk(c + k, "pending", 6'b0, 6'b0, 6'b0, 8'd250));
    sw_if.SW = 6'b010000;
    repeat (4) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    repeat (2) @(negedge CLOCK_50);
    check_outputs_zero("mid_rst_hold");
    exp_state = '0;
    exp_cnt   = '0;
    push_change(6'b010000, "rst_rel");
    RESET_N = 1'b1;
    repeat (8) @(negedge CLOCK_50);

    repeat (2) @(negedge CLOCK_50);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
